// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: instruction selectors,
// FSM state encoding and shift-kind encoding.
package shift_sequencer_pkg;

  // {opcode, func} selectors for the R-type shifts
  localparam logic [11:0] SelSll  = 12'b000000_000000;
  localparam logic [11:0] SelSrl  = 12'b000000_000010;
  localparam logic [11:0] SelSra  = 12'b000000_000011;
  localparam logic [11:0] SelSllv = 12'b000000_000100;
  localparam logic [11:0] SelSrlv = 12'b000000_000110;
  localparam logic [11:0] SelSrav = 12'b000000_000111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KindLeft   = 2'd0,
    KindRightL = 2'd1,
    KindRightA = 2'd2
  } kind_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the ID/EX stage and the shift sequencer.
interface shift_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ss_start_i;
  logic [5:0]            ss_opcode_i;
  logic [5:0]            ss_func_i;
  logic [4:0]            ss_shamt_i;
  logic [DATA_WIDTH-1:0] ss_rs_i;
  logic [DATA_WIDTH-1:0] ss_data_i;
  logic                  ss_busy_o;
  logic                  ss_done_o;
  logic [DATA_WIDTH-1:0] ss_result_o;
  logic                  ss_shift_o;

  modport master (
    output ss_start_i, ss_opcode_i, ss_func_i, ss_shamt_i, ss_rs_i, ss_data_i,
    input  ss_busy_o, ss_done_o, ss_result_o, ss_shift_o
  );

  modport slave (
    input  ss_start_i, ss_opcode_i, ss_func_i, ss_shamt_i, ss_rs_i, ss_data_i,
    output ss_busy_o, ss_done_o, ss_result_o, ss_shift_o
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-step shifter used by the sequencer datapath.
// Sign fill exists only when SHIFT_SEQ_ARITH_EN is defined.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  kind_e                 kind,
  input  logic [4:0]            amount,
  output logic [DATA_WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (kind)
      KindLeft:   shifted = value << amount;
      KindRightL: shifted = value >> amount;
`ifdef SHIFT_SEQ_ARITH_EN
      // Top bit of the accumulator still holds the latched sign
      KindRightA: shifted = DATA_WIDTH'($signed(value) >>> amount);
`endif
      default:    shifted = value;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: applies a MIPS shift STEP_BITS bits per clock,
// stalling the pipeline via busy. SHIFT_SEQ_ARITH_EN enables SRA/SRAV.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP_BITS  = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  shift_sequencer_if.slave ss
);

  localparam logic [5:0] StepAmt = 6'(STEP_BITS);

  logic [11:0]           sel;
  logic                  shift_ok;
  logic                  use_rs;
  kind_e                 kind_sel;
  logic [4:0]            amount_sel;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [4:0]            remaining_q;
  kind_e                 kind_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic [4:0]            step_m;
  logic [DATA_WIDTH-1:0] step_out;
  logic                  unused_rs;

  assign sel       = {ss.ss_opcode_i, ss.ss_func_i};
  assign unused_rs = ^ss.ss_rs_i[DATA_WIDTH-1:5];

  always_comb begin
    shift_ok = 1'b0;
    use_rs   = 1'b0;
    kind_sel = KindLeft;
    case (sel)
      SelSll:  shift_ok = 1'b1;
      SelSrl:  begin shift_ok = 1'b1; kind_sel = KindRightL; end
      SelSllv: begin shift_ok = 1'b1; use_rs = 1'b1; end
      SelSrlv: begin shift_ok = 1'b1; use_rs = 1'b1; kind_sel = KindRightL; end
`ifdef SHIFT_SEQ_ARITH_EN
      SelSra:  begin shift_ok = 1'b1; kind_sel = KindRightA; end
      SelSrav: begin shift_ok = 1'b1; use_rs = 1'b1; kind_sel = KindRightA; end
`endif
      default: shift_ok = 1'b0;
    endcase
  end

  assign amount_sel = use_rs ? ss.ss_rs_i[4:0] : ss.ss_shamt_i;

  // Step size is min(STEP_BITS, remaining)
  assign step_m = ({1'b0, remaining_q} >= StepAmt) ? StepAmt[4:0] : remaining_q;

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_step (
    .value   (acc_q),
    .kind    (kind_q),
    .amount  (step_m),
    .shifted (step_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      remaining_q <= '0;
      kind_q      <= KindLeft;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ss.ss_start_i && shift_ok) begin
            acc_q       <= ss.ss_data_i;
            remaining_q <= amount_sel;
            kind_q      <= kind_sel;
            busy_q      <= 1'b1;
            if (amount_sel == 5'd0) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= ss.ss_data_i;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          acc_q       <= step_out;
          remaining_q <= remaining_q - step_m;
          if (remaining_q == step_m) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= step_out;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ss.ss_busy_o   = busy_q;
  assign ss.ss_done_o   = done_q;
  assign ss.ss_result_o = result_q;
  assign ss.ss_shift_o  = shift_ok;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with STEP_BITS = 1, 2 and 4 instances.
module tb_shift_sequencer;

  logic clk;
  logic rst1, rst2, rst4;
  int   checks;
  int   failures;

  shift_sequencer_if #(.DATA_WIDTH(32)) if1 ();
  shift_sequencer_if #(.DATA_WIDTH(32)) if2 ();
  shift_sequencer_if #(.DATA_WIDTH(32)) if4 ();

  shift_sequencer #(.STEP_BITS(1), .DATA_WIDTH(32)) u_s1 (.clk(clk), .reset(rst1), .ss(if1));
  shift_sequencer #(.STEP_BITS(2), .DATA_WIDTH(32)) u_s2 (.clk(clk), .reset(rst2), .ss(if2));
  shift_sequencer #(.STEP_BITS(4), .DATA_WIDTH(32)) u_s4 (.clk(clk), .reset(rst4), .ss(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] data);
    if1.ss_opcode_i = op; if1.ss_func_i = fn; if1.ss_shamt_i = sa;
    if1.ss_rs_i = rs; if1.ss_data_i = data;
    if2.ss_opcode_i = op; if2.ss_func_i = fn; if2.ss_shamt_i = sa;
    if2.ss_rs_i = rs; if2.ss_data_i = data;
    if4.ss_opcode_i = op; if4.ss_func_i = fn; if4.ss_shamt_i = sa;
    if4.ss_rs_i = rs; if4.ss_data_i = data;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    if1.ss_start_i = 1'b0; if2.ss_start_i = 1'b0; if4.ss_start_i = 1'b0;
    set_ops(6'd0, 6'd0, 5'd0, 32'd0, 32'd0);
    rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
    tick();
    tick();
    check("rst_busy1", {31'd0, if1.ss_busy_o}, 32'd0);
    check("rst_done1", {31'd0, if1.ss_done_o}, 32'd0);
    check("rst_res1", if1.ss_result_o, 32'd0);
    check("rst_busy4", {31'd0, if4.ss_busy_o}, 32'd0);
    check("rst_res2", if2.ss_result_o, 32'd0);
    rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;

    // Selector decode
    set_ops(6'b000000, 6'b000000, 5'd0, 32'd0, 32'd0);
    #1 check("dec_sll", {31'd0, if1.ss_shift_o}, 32'd1);
    set_ops(6'b000000, 6'b000110, 5'd0, 32'd0, 32'd0);
    #1 check("dec_srlv", {31'd0, if1.ss_shift_o}, 32'd1);
    set_ops(6'b000001, 6'b000000, 5'd0, 32'd0, 32'd0);
    #1 check("dec_badop", {31'd0, if1.ss_shift_o}, 32'd0);
    set_ops(6'b000000, 6'b000011, 5'd0, 32'd0, 32'd0);
`ifdef SHIFT_SEQ_ARITH_EN
    #1 check("dec_sra", {31'd0, if1.ss_shift_o}, 32'd1);
`else
    #1 check("dec_sra", {31'd0, if1.ss_shift_o}, 32'd0);
`endif

    // STEP 1, SLL 1 by 4: busy 5 cycles, done after E4
    set_ops(6'b000000, 6'b000000, 5'd4, 32'd0, 32'h0000_0001);
    if1.ss_start_i = 1'b1;
    tick();
    if1.ss_start_i = 1'b0;
    check("sll_busy_e0", {31'd0, if1.ss_busy_o}, 32'd1);
    check("sll_done_e0", {31'd0, if1.ss_done_o}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("sll_busy_e%0d", i), {31'd0, if1.ss_busy_o}, 32'd1);
      check($sformatf("sll_done_e%0d", i), {31'd0, if1.ss_done_o}, (i == 4) ? 32'd1 : 32'd0);
    end
    check("sll_result", if1.ss_result_o, 32'h0000_0010);
    tick();
    check("sll_busy_end", {31'd0, if1.ss_busy_o}, 32'd0);
    check("sll_done_end", {31'd0, if1.ss_done_o}, 32'd0);
    check("sll_hold", if1.ss_result_o, 32'h0000_0010);

    // STEP 4, SRAV 0x80000000 by rs[4:0]=3 (shamt deliberately different)
    set_ops(6'b000000, 6'b000111, 5'd9, 32'h0000_0023, 32'h8000_0000);
    if4.ss_start_i = 1'b1;
`ifdef SHIFT_SEQ_ARITH_EN
    #1 check("srav_shift", {31'd0, if4.ss_shift_o}, 32'd1);
    tick();
    if4.ss_start_i = 1'b0;
    check("srav_busy_e0", {31'd0, if4.ss_busy_o}, 32'd1);
    check("srav_done_e0", {31'd0, if4.ss_done_o}, 32'd0);
    tick();
    check("srav_done_e1", {31'd0, if4.ss_done_o}, 32'd1);
    check("srav_result", if4.ss_result_o, 32'hF000_0000);
    tick();
    check("srav_busy_end", {31'd0, if4.ss_busy_o}, 32'd0);
`else
    #1 check("srav_shift", {31'd0, if4.ss_shift_o}, 32'd0);
    tick();
    if4.ss_start_i = 1'b0;
    check("srav_busy_e0", {31'd0, if4.ss_busy_o}, 32'd0);
    check("srav_done_e0", {31'd0, if4.ss_done_o}, 32'd0);
    tick();
    check("srav_done_e1", {31'd0, if4.ss_done_o}, 32'd0);
    check("srav_result", if4.ss_result_o, 32'h0000_0000);
`endif

    // STEP 4, SLLV 3 by 6: partial last step (4 then 2), done after E2
    set_ops(6'b000000, 6'b000100, 5'd0, 32'h0000_0006, 32'h0000_0003);
    if4.ss_start_i = 1'b1;
    tick();
    if4.ss_start_i = 1'b0;
    tick();
    check("sllv_done_e1", {31'd0, if4.ss_done_o}, 32'd0);
    tick();
    check("sllv_done_e2", {31'd0, if4.ss_done_o}, 32'd1);
    check("sllv_result", if4.ss_result_o, 32'h0000_00C0);

    // STEP 1, SRL all-ones by 31 with a stray start at E10
    set_ops(6'b000000, 6'b000010, 5'd31, 32'd0, 32'hFFFF_FFFF);
    if1.ss_start_i = 1'b1;
    tick();
    if1.ss_start_i = 1'b0;
    set_ops(6'b000000, 6'b000000, 5'd1, 32'd0, 32'h0000_0000);
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) if1.ss_start_i = 1'b1;
      tick();
      if1.ss_start_i = 1'b0;
      check($sformatf("srl_done_e%0d", i), {31'd0, if1.ss_done_o}, (i == 31) ? 32'd1 : 32'd0);
    end
    check("srl_result", if1.ss_result_o, 32'h0000_0001);
    tick();
    check("srl_busy_end", {31'd0, if1.ss_busy_o}, 32'd0);
    tick();
    check("srl_no_queue", {31'd0, if1.ss_busy_o}, 32'd0);

    // STEP 2, SLL by 0: done right after E0, busy one cycle
    set_ops(6'b000000, 6'b000000, 5'd0, 32'd0, 32'h1234_5678);
    if2.ss_start_i = 1'b1;
    tick();
    if2.ss_start_i = 1'b0;
    check("k0_busy_e0", {31'd0, if2.ss_busy_o}, 32'd1);
    check("k0_done_e0", {31'd0, if2.ss_done_o}, 32'd1);
    check("k0_result", if2.ss_result_o, 32'h1234_5678);
    tick();
    check("k0_busy_e1", {31'd0, if2.ss_busy_o}, 32'd0);
    check("k0_done_e1", {31'd0, if2.ss_done_o}, 32'd0);

    // STEP 2, SRL all-ones by 20, reset sampled at E4 together with start
    set_ops(6'b000000, 6'b000010, 5'd20, 32'd0, 32'hFFFF_FFFF);
    if2.ss_start_i = 1'b1;
    tick();
    if2.ss_start_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("rs_busy_e%0d", i), {31'd0, if2.ss_busy_o}, 32'd1);
    end
    rst2 = 1'b1;
    if2.ss_start_i = 1'b1;
    tick();
    check("rs_busy_e4", {31'd0, if2.ss_busy_o}, 32'd0);
    check("rs_done_e4", {31'd0, if2.ss_done_o}, 32'd0);
    check("rs_res_e4", if2.ss_result_o, 32'd0);
    rst2 = 1'b0;
    tick();
    if2.ss_start_i = 1'b0;
    check("rs_busy_e5", {31'd0, if2.ss_busy_o}, 32'd1);
    for (int i = 6; i <= 15; i++) begin
      tick();
      check($sformatf("rs_done_e%0d", i), {31'd0, if2.ss_done_o}, (i == 15) ? 32'd1 : 32'd0);
    end
    check("rs_result", if2.ss_result_o, 32'h0000_0FFF);

    // Unsupported selector: ignored, result held
    set_ops(6'b000000, 6'b100000, 5'd3, 32'd0, 32'hDEAD_BEEF);
    if1.ss_start_i = 1'b1;
    #1 check("bad_shift", {31'd0, if1.ss_shift_o}, 32'd0);
    tick();
    if1.ss_start_i = 1'b0;
    check("bad_busy", {31'd0, if1.ss_busy_o}, 32'd0);
    check("bad_done", {31'd0, if1.ss_done_o}, 32'd0);
    tick();
    check("bad_done2", {31'd0, if1.ss_done_o}, 32'd0);
    check("bad_hold", if1.ss_result_o, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
